// File: rtl/pcie_phy_pkg.sv
// Shared PHY types: link rates, TX arbiter states, tuser bit positions and
// default SKP intervals.
package pcie_phy_pkg;

  typedef enum logic [2:0] {
    RATE_GEN1 = 3'd0,
    RATE_GEN2 = 3'd1,
    RATE_GEN3 = 3'd2,
    RATE_GEN4 = 3'd3,
    RATE_GEN5 = 3'd4
  } rate_speed_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DLLP = 2'd1,
    ST_TLP  = 2'd2,
    ST_SKP  = 2'd3
  } arb_st_e;

  localparam int TUSER_DLLP_BIT = 0;
  localparam int TUSER_TLP_BIT  = 1;

  localparam int SKP_INTERVAL_GEN12_DEFAULT = 1180;
  localparam int SKP_INTERVAL_GEN3_DEFAULT  = 370;
  localparam int SKP_TIMER_WIDTH            = 16;

endpackage

// File: rtl/phy_tx_arbiter_skp_timer.sv
// SKP interval timer: counts while the link is up, raises pending at the
// rate-dependent interval and holds until the ordered set is acknowledged.
module skp_interval_timer
  import pcie_phy_pkg::*;
#(
  parameter int SKP_INTERVAL_GEN12 = SKP_INTERVAL_GEN12_DEFAULT,
  parameter int SKP_INTERVAL_GEN3  = SKP_INTERVAL_GEN3_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  rate_speed_e rate,
  input  logic        run,
  input  logic        clear,
  input  logic        ack,
  output logic        pending
);

  logic [SKP_TIMER_WIDTH-1:0] count;
  logic [SKP_TIMER_WIDTH-1:0] interval;
  rate_speed_e                rate_q;

  always_comb begin
    interval = (rate >= RATE_GEN3) ? SKP_TIMER_WIDTH'(SKP_INTERVAL_GEN3)
                                   : SKP_TIMER_WIDTH'(SKP_INTERVAL_GEN12);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count   <= '0;
      pending <= 1'b0;
      rate_q  <= rate;
    end else begin
      rate_q <= rate;
      if (clear) begin
        count   <= '0;
        pending <= 1'b0;
      end else if (ack) begin
        count   <= '0;
        pending <= 1'b0;
      end else if (rate != rate_q) begin
        // A rate change restarts the interval but keeps any request already owed.
        count <= '0;
      end else if (run) begin
        if (count == interval - 1'b1) begin
          pending <= 1'b1;
        end else begin
          count <= count + 1'b1;
          if (count + 1'b1 == interval - 1'b1) pending <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/phy_tx_arbiter.sv
// Packet-atomic scheduler sharing the TX framing datapath between the DLLP and
// TLP streams, with periodic reservation of the datapath for SKP insertion.
module phy_tx_arbiter
  import pcie_phy_pkg::*;
#(
  parameter int DATA_WIDTH         = 32,
  parameter int KEEP_WIDTH         = DATA_WIDTH / 8,
  parameter int USER_WIDTH         = 4,
  parameter int MAX_DLLP_BURST     = 4,
  parameter int SKP_INTERVAL_GEN12 = SKP_INTERVAL_GEN12_DEFAULT,
  parameter int SKP_INTERVAL_GEN3  = SKP_INTERVAL_GEN3_DEFAULT
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  rate_speed_e           curr_data_rate_i,
  input  logic                  link_up_i,
  input  logic [DATA_WIDTH-1:0] s_dllp_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_dllp_axis_tkeep,
  input  logic                  s_dllp_axis_tvalid,
  input  logic                  s_dllp_axis_tlast,
  output logic                  s_dllp_axis_tready,
  input  logic [DATA_WIDTH-1:0] s_tlp_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_tlp_axis_tkeep,
  input  logic                  s_tlp_axis_tvalid,
  input  logic                  s_tlp_axis_tlast,
  output logic                  s_tlp_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  output logic [USER_WIDTH-1:0] m_axis_tuser,
  input  logic                  m_axis_tready,
  output logic                  skp_req_o,
  input  logic                  skp_ack_i,
  output arb_st_e               arb_state
);

  // Handshake rule on every AXIS port: a beat transfers on a rising clk edge
  // where tvalid and tready are both high; tvalid never depends on tready.

  localparam int BURST_W = $clog2(MAX_DLLP_BURST + 1);
  localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_DLLP_BURST);

  arb_st_e              state, state_next;
  logic [BURST_W-1:0]   burst_cnt, burst_next;
  logic                 skp_pending;
  logic                 skp_clear;
  logic                 skp_ack_valid;

  assign arb_state     = state;
  assign skp_clear     = (state == ST_IDLE) && !link_up_i;
  assign skp_ack_valid = (state == ST_SKP) && skp_ack_i;

  skp_interval_timer #(
    .SKP_INTERVAL_GEN12 (SKP_INTERVAL_GEN12),
    .SKP_INTERVAL_GEN3  (SKP_INTERVAL_GEN3)
  ) u_skp_timer (
    .clk     (clk_i),
    .rst     (rst_i),
    .rate    (curr_data_rate_i),
    .run     (link_up_i),
    .clear   (skp_clear),
    .ack     (skp_ack_valid),
    .pending (skp_pending)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= ST_IDLE;
      burst_cnt <= '0;
    end else begin
      state     <= state_next;
      burst_cnt <= burst_next;
    end
  end

  always_comb begin
    state_next         = state;
    burst_next         = burst_cnt;
    m_axis_tdata       = '0;
    m_axis_tkeep       = '0;
    m_axis_tvalid      = 1'b0;
    m_axis_tlast       = 1'b0;
    m_axis_tuser       = '0;
    s_dllp_axis_tready = 1'b0;
    s_tlp_axis_tready  = 1'b0;
    skp_req_o          = 1'b0;

    case (state)
      ST_IDLE: begin
        // Decision is registered: one bubble cycle per packet.
        if (link_up_i) begin
          if (skp_pending) begin
            state_next = ST_SKP;
          end else if (s_dllp_axis_tvalid && (!s_tlp_axis_tvalid || burst_cnt < BURST_MAX)) begin
            state_next = ST_DLLP;
            if (s_tlp_axis_tvalid)
              burst_next = (burst_cnt == BURST_MAX) ? BURST_MAX : burst_cnt + 1'b1;
            else
              burst_next = '0;
          end else if (s_tlp_axis_tvalid) begin
            state_next = ST_TLP;
          end
        end
      end
      ST_DLLP: begin
        m_axis_tdata                 = s_dllp_axis_tdata;
        m_axis_tkeep                 = s_dllp_axis_tkeep;
        m_axis_tvalid                = s_dllp_axis_tvalid;
        m_axis_tlast                 = s_dllp_axis_tlast;
        m_axis_tuser[TUSER_DLLP_BIT] = 1'b1;
        s_dllp_axis_tready           = m_axis_tready;
        if (s_dllp_axis_tvalid && m_axis_tready && s_dllp_axis_tlast)
          state_next = ST_IDLE;
      end
      ST_TLP: begin
        m_axis_tdata                = s_tlp_axis_tdata;
        m_axis_tkeep                = s_tlp_axis_tkeep;
        m_axis_tvalid               = s_tlp_axis_tvalid;
        m_axis_tlast                = s_tlp_axis_tlast;
        m_axis_tuser[TUSER_TLP_BIT] = 1'b1;
        s_tlp_axis_tready           = m_axis_tready;
        if (s_tlp_axis_tvalid && m_axis_tready && s_tlp_axis_tlast) begin
          state_next = ST_IDLE;
          burst_next = '0;
        end
      end
      ST_SKP: begin
        skp_req_o = 1'b1;
        if (skp_ack_i) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

endmodule
